// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and its slave.
// The master drives select/enable/address/data; the slave answers.
interface apb_arb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_arb_master.sv
// Round-robin APB master shared by NREQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_arb_master #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  apb_arb_master_if.master  apb
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] elig;
  logic [IW-1:0]   pick;
  logic            pick_ok;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // The requester just completed is still holding req_valid this cycle
  assign elig = req_valid & ~rsp_valid_q;

  always_comb begin
    pick_ok = 1'b0;
    pick    = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_ok && elig[(int'(last_q) + k) % NREQ]) begin
        pick_ok = 1'b1;
        pick    = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d  = SETUP;
          last_d   = pick;
          psel_d   = 1'b1;
          pwrite_d = req_write[pick];
          paddr_d  = req_addr[int'(pick)*AW +: AW];
          pwdata_d = req_wdata[int'(pick)*DW +: DW];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (apb.pready) begin
          state_d             = IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_rdata_d         = pwrite_q ? '0 : apb.prdata;
          rsp_err_d           = apb.pslverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d             = IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      last_q      <= IW'(NREQ - 1);
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule
